// File: rtl/recursive_doubling_pkg.sv
// Shared types and helpers for the recursive-doubling (Kogge-Stone) adder.
package recursive_doubling_pkg;

  // Generate/propagate pair carried through every node of the prefix tree
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Bit-level pre-processing: generate and propagate from one operand bit pair
  function automatic gp_t gp_pre(input logic a, input logic b);
    gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

  // Prefix operator: combine a higher-order span with the adjacent lower span
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/recursive_doubling_prefix_cell.sv
// Single (G,P) combine node of the recursive-doubling prefix network.
module rd_prefix_cell
  import recursive_doubling_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t gp
);

  // G = Gh | Ph&Gl, P = Ph&Pl
  assign gp = gp_combine(hi, lo);

endmodule

// File: rtl/recursive_doubling.sv
// Registered WIDTH-bit adder with a log2(WIDTH)-depth Kogge-Stone carry network.
module recursive_doubling
  import recursive_doubling_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  gp_t [WIDTH-1:0]  gp0;
  gp_t [WIDTH-1:0]  gp_fin;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;

  // Pre-processing: per-bit generate/propagate
  for (genvar i = 0; i < WIDTH; i++) begin : g_pre
    assign gp0[i] = gp_pre(a[i], b[i]);
  end

  // Prefix levels; each level doubles the span covered by every node
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned D = 2 ** k;
    gp_t [WIDTH-1:0] gp_in;
    gp_t [WIDTH-1:0] gp_out;

    if (k == 0) begin : g_first
      assign gp_in = gp0;
    end else begin : g_next
      assign gp_in = g_lvl[k-1].gp_out;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cell
        rd_prefix_cell u_cell (
          .hi (gp_in[i]),
          .lo (gp_in[i-D]),
          .gp (gp_out[i])
        );
      end else begin : g_pass
        assign gp_out[i] = gp_in[i];
      end
    end
  end

  assign gp_fin = g_lvl[LEVELS-1].gp_out;

  // Post-processing: carries come straight from the final group generates
  assign carry[0] = 1'b0;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign carry[i] = gp_fin[i-1].g;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_sum
    assign sum_next[i] = gp0[i].p ^ carry[i];
  end

  assign cout_next = gp_fin[WIDTH-1].g;

  // Output register; loads every cycle, valid only qualifies the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      sum       <= sum_next;
      cout      <= cout_next;
      valid_out <= valid_in;
    end
  end

endmodule

// File: tb/tb_recursive_doubling.sv
// Directed and random checks of recursive_doubling at WIDTH=32 and WIDTH=8.
module tb_recursive_doubling;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        valid_out;
  logic [31:0] sum;
  logic        cout;

  logic        valid_in8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        valid_out8;
  logic [7:0]  sum8;
  logic        cout8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  recursive_doubling #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .sum       (sum),
    .cout      (cout)
  );

  recursive_doubling #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in8),
    .a         (a8),
    .b         (b8),
    .valid_out (valid_out8),
    .sum       (sum8),
    .cout      (cout8)
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rv;
    logic [7:0]  ra8;
    logic [7:0]  rb8;
    logic        rv8;
    logic [32:0] exp32;
    logic [8:0]  exp8;

    // Reset state
    #1;
    check("rst_sum32", 33'({cout, sum}), 33'h0);
    check("rst_vld32", 33'(valid_out), 33'h0);
    check("rst_sum8", 33'({cout8, sum8}), 33'h0);
    check("rst_vld8", 33'(valid_out8), 33'h0);
    #3;
    rst_n = 1'b1;

    // Mixed generate/propagate pattern; 8-bit MSB carry-out
    a = 32'hD5554554; b = 32'hAAAAAAAA; valid_in = 1'b1;
    a8 = 8'h80; b8 = 8'h80; valid_in8 = 1'b1;
    step();
    check("v1_sum32", 33'({cout, sum}), 33'h1_7FFF_EFFE);
    check("v1_vld32", 33'(valid_out), 33'h1);
    check("w8_8080", 33'({cout8, sum8}), 33'h100);
    check("w8_vld1", 33'(valid_out8), 33'h1);

    // All propagate, no generate; 8-bit carry into MSB
    a = 32'h55555555; b = 32'hAAAAAAAA; valid_in = 1'b0;
    a8 = 8'h7F; b8 = 8'h01; valid_in8 = 1'b0;
    step();
    check("v2_sum32", 33'({cout, sum}), 33'h0_FFFF_FFFF);
    check("v2_vld32", 33'(valid_out), 33'h0);
    check("w8_7f01", 33'({cout8, sum8}), 33'h080);
    check("w8_vld0", 33'(valid_out8), 33'h0);

    // Full-length carry chain
    a = 32'hFFFFFFFF; b = 32'h00000001; valid_in = 1'b1;
    a8 = 8'hFF; b8 = 8'h01;
    step();
    check("chain_sum32", 33'({cout, sum}), 33'h1_0000_0000);
    check("chain_w8", 33'({cout8, sum8}), 33'h100);

    // Zero operands
    a = '0; b = '0;
    a8 = '0; b8 = '0;
    step();
    check("zero_sum32", 33'({cout, sum}), 33'h0);
    check("zero_w8", 33'({cout8, sum8}), 33'h0);

    // Reload, then assert reset between edges
    a = 32'hD5554554; b = 32'hAAAAAAAA; valid_in = 1'b1;
    step();
    check("pre_rst_sum32", 33'({cout, sum}), 33'h1_7FFF_EFFE);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum32", 33'({cout, sum}), 33'h0);
    check("async_rst_vld32", 33'(valid_out), 33'h0);
    a = 32'h00000001; b = 32'h00000002; valid_in = 1'b1;
    #2;
    check("hold_rst_sum32", 33'({cout, sum}), 33'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_sum32", 33'({cout, sum}), 33'h3);
    check("post_rst_vld32", 33'(valid_out), 33'h1);

    // Back-to-back random stream
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom; rb = $urandom; rv = 1'($urandom_range(1, 0));
      ra8 = 8'($urandom); rb8 = 8'($urandom); rv8 = 1'($urandom_range(1, 0));
      a = ra; b = rb; valid_in = rv;
      a8 = ra8; b8 = rb8; valid_in8 = rv8;
      exp32 = {1'b0, ra} + {1'b0, rb};
      exp8 = {1'b0, ra8} + {1'b0, rb8};
      step();
      check("rnd_sum32", 33'({cout, sum}), exp32);
      check("rnd_vld32", 33'(valid_out), 33'(rv));
      check("rnd_sum8", 33'({cout8, sum8}), 33'(exp8));
      check("rnd_vld8", 33'(valid_out8), 33'(rv8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
